// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module : pipe_ctrl_pkg
//  Brief  : Shared types and stage indices for the pipeline control unit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int NUM_STAGES = 5;
    localparam int STG_IF     = 0;
    localparam int STG_ID     = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

    // Normal advance: every stage moves up one; kill_id drops the instruction entering ID.
    function automatic logic [NUM_STAGES-1:0] advance_valid(
        input logic [NUM_STAGES-1:0] v,
        input logic                  kill_id,
        input logic                  fetch
    );
        return {v[NUM_STAGES-2:STG_ID], v[STG_IF] & ~kill_id, fetch};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_unit_hazard_detect.sv
// ============================================================================
//  Module : hazard_detect
//  Brief  : Combinational load-use compare between decode sources and EX load.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             use1,
    input  logic             use2,
    input  logic             mem_read,
    input  logic [REG_W-1:0] dst,
    output logic             hazard
);

    // R0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard = mem_read && (dst != '0) &&
                    ((use1 && (src1 == dst)) || (use2 && (src2 == dst)));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl_unit.sv
// ============================================================================
//  Module : pipeline_ctrl_unit
//  Brief  : 5-stage pipeline sequencer (hazards, branch squash, mem freeze, HLT
//           drain). Optional tracing enabled by macro PIPE_TRACE_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W  = 4,
    parameter int MEM_TO = 15
`ifdef PIPE_TRACE_EN
    ,
    parameter int ID_W   = 8,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_W-1:0]      id_src1,
    input  logic [REG_W-1:0]      id_src2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic                  id_halt,
    input  logic                  branch_taken,
    input  logic                  ex_mem_read,
    input  logic [REG_W-1:0]      ex_dst,
    input  logic                  mem_busy,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  ex_mem_we,
    output logic                  mem_wb_we,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  stall,
    output logic                  flush,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  halted,
    output logic                  mem_timeout
`ifdef PIPE_TRACE_EN
    ,
    output logic [5*ID_W-1:0]     trace_ids,
    output logic [CNT_W-1:0]      retire_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TO + 1) + 1;
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MEM_TO);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_STAGES-1:0]   r_valid;
    logic [NUM_STAGES-1:0]   w_valid_nxt;
    logic [2:0]              r_hlt_tag;
    logic [2:0]              w_tag_nxt;
    logic                    r_lu_done;
    logic                    w_lu_stall;
    logic                    w_hazard;
    logic                    w_busy;
    logic                    w_fetch;
    logic [WAIT_W-1:0]       r_wait;
    logic                    r_timeout;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .src1     (id_src1),
        .src2     (id_src2),
        .use1     (id_use1),
        .use2     (id_use2),
        .mem_read (ex_mem_read),
        .dst      (ex_dst),
        .hazard   (w_hazard)
    );

    assign w_busy      = mem_busy && (r_state != ST_HALTED);
    assign stage_valid = r_valid;
    assign halted      = (r_state == ST_HALTED);
    assign mem_timeout = r_timeout;
    assign flush       = if_id_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_valid   <= '0;
            r_hlt_tag <= '0;
            r_lu_done <= 1'b0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_hlt_tag <= w_tag_nxt;
            // Remember a serviced load-use so a held hazard only costs one bubble.
            if (!w_busy) begin
                r_lu_done <= w_lu_stall;
            end
            if (w_busy) begin
                if (r_wait != C_WAIT_MAX) begin
                    r_wait <= r_wait + WAIT_W'(1);
                end else begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wait <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_tag_nxt   = r_hlt_tag;
        w_lu_stall  = 1'b0;
        w_fetch     = 1'b0;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall       = 1'b0;

        if (!rst) begin
            if (r_state == ST_HALTED) begin
                w_valid_nxt = '0;
            end else if (mem_busy) begin
                stall = 1'b1;
            end else if (w_hazard && !r_lu_done) begin
                w_lu_stall  = 1'b1;
                stall       = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
                w_valid_nxt = {r_valid[STG_MEM], r_valid[STG_EX], 1'b0,
                               r_valid[STG_ID], r_valid[STG_IF]};
            end else begin
                pc_we     = 1'b1;
                if_id_we  = 1'b1;
                ex_mem_we = 1'b1;
                mem_wb_we = 1'b1;
                if (r_state == ST_RUN) begin
                    w_fetch = 1'b1;
                    if (id_halt && r_valid[STG_ID]) begin
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                        w_fetch     = 1'b0;
                        w_state_nxt = ST_DRAIN;
                        w_tag_nxt   = 3'b001;
                    end else if (branch_taken && r_valid[STG_ID]) begin
                        if_id_flush = 1'b1;
                    end
                end else begin
                    pc_we       = 1'b0;
                    if_id_flush = 1'b1;
                end
                w_valid_nxt = advance_valid(r_valid, if_id_flush, w_fetch);
            end

            // HLT token walks EX -> MEM -> WB whenever the back end advances.
            if (r_state == ST_DRAIN && ex_mem_we) begin
                if (r_hlt_tag[2]) begin
                    w_state_nxt = ST_HALTED;
                    w_valid_nxt = '0;
                    w_tag_nxt   = '0;
                end else begin
                    w_tag_nxt   = {r_hlt_tag[1:0], 1'b0};
                end
            end
        end
    end

`ifdef PIPE_TRACE_EN
    logic [ID_W-1:0]  r_id_cnt;
    logic [ID_W-1:0]  r_tr_id;
    logic [ID_W-1:0]  r_tr_ex;
    logic [ID_W-1:0]  r_tr_mem;
    logic [ID_W-1:0]  r_tr_wb;
    logic [CNT_W-1:0] r_retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_cnt <= '0;
            r_tr_id  <= '0;
            r_tr_ex  <= '0;
            r_tr_mem <= '0;
            r_tr_wb  <= '0;
            r_retire <= '0;
        end else begin
            if (if_id_we) begin
                r_tr_id <= r_id_cnt;
                if (r_valid[STG_IF] && !if_id_flush) begin
                    r_id_cnt <= r_id_cnt + ID_W'(1);
                end
            end
            if (ex_mem_we) begin
                r_tr_ex  <= r_tr_id;
                r_tr_mem <= r_tr_ex;
                r_tr_wb  <= r_tr_mem;
            end
            if (mem_wb_we && r_valid[STG_WB]) begin
                r_retire <= r_retire + CNT_W'(1);
            end
        end
    end

    assign trace_ids  = {r_tr_wb, r_tr_mem, r_tr_ex, r_tr_id, r_id_cnt};
    assign retire_cnt = r_retire;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl_unit.sv
// ============================================================================
//  Module : tb_pipeline_ctrl_unit
//  Brief  : Directed self-checking bench for pipeline_ctrl_unit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, ex_dst;
    logic       id_use1, id_use2, id_halt, branch_taken, ex_mem_read, mem_busy;
    logic       pc_we, if_id_we, ex_mem_we, mem_wb_we;
    logic       if_id_flush, id_ex_flush, stall, flush, halted, mem_timeout;
    logic [4:0] stage_valid;
    logic [3:0] en;
`ifdef PIPE_TRACE_EN
    logic [39:0] trace_ids;
    logic [15:0] retire_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    assign en = {pc_we, if_id_we, ex_mem_we, mem_wb_we};

    always #5 clk = ~clk;

    pipeline_ctrl_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .id_halt      (id_halt),
        .branch_taken (branch_taken),
        .ex_mem_read  (ex_mem_read),
        .ex_dst       (ex_dst),
        .mem_busy     (mem_busy),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .stall        (stall),
        .flush        (flush),
        .stage_valid  (stage_valid),
        .halted       (halted),
        .mem_timeout  (mem_timeout)
`ifdef PIPE_TRACE_EN
        ,
        .trace_ids    (trace_ids),
        .retire_cnt   (retire_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; ex_dst = 4'd0;
        id_use1 = 1'b0; id_use2 = 1'b0; id_halt = 1'b0;
        branch_taken = 1'b0; ex_mem_read = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic fill();
        clear_inputs();
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_reset();
        logic [4:0] exp_sv;
        clear_inputs();
        mem_busy = 1'b1;
        rst = 1'b1;
        step();
        n_cmp++; if (stage_valid !== 5'b0) begin n_fail++; $display("FAIL reset_sv got %b want 00000", stage_valid); end
        n_cmp++; if ({en, stall, halted, mem_timeout} !== 7'b0) begin n_fail++; $display("FAIL reset_outs got %b want 0000000", {en, stall, halted, mem_timeout}); end
        mem_busy = 1'b0;
        rst = 1'b0;
        #1;
        exp_sv = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_sv = {exp_sv[3:0], 1'b1};
            n_cmp++; if (stage_valid !== exp_sv) begin n_fail++; $display("FAIL fill_sv[%0d] got %b want %b", i, stage_valid, exp_sv); end
        end
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_dst = 4'd3; id_src1 = 4'd3; id_use1 = 1'b1;
        #1;
        n_cmp++; if ({en, id_ex_flush, stall} !== 6'b0011_11) begin n_fail++; $display("FAIL lu_outs got %b want 001111", {en, id_ex_flush, stall}); end
        step();
        n_cmp++; if (stage_valid !== 5'b11011) begin n_fail++; $display("FAIL lu_sv got %b want 11011", stage_valid); end
        n_cmp++; if ({stall, id_ex_flush, pc_we} !== 3'b001) begin n_fail++; $display("FAIL lu_once got %b want 001", {stall, id_ex_flush, pc_we}); end
        step();
        n_cmp++; if (stage_valid !== 5'b10111) begin n_fail++; $display("FAIL lu_after_sv got %b want 10111", stage_valid); end
        ex_dst = 4'd0; id_src1 = 4'd0;
        #1;
        n_cmp++; if ({stall, id_ex_flush} !== 2'b00) begin n_fail++; $display("FAIL lu_r0 got %b want 00", {stall, id_ex_flush}); end
        step();
        ex_dst = 4'd5; id_src1 = 4'd1; id_src2 = 4'd5; id_use2 = 1'b1;
        #1;
        n_cmp++; if ({stall, id_ex_flush, if_id_we} !== 3'b110) begin n_fail++; $display("FAIL lu_src2 got %b want 110", {stall, id_ex_flush, if_id_we}); end
        id_use2 = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_unused got %b want 0", stall); end
        step();
        clear_inputs();
    endtask

    task automatic test_branch();
        fill();
        branch_taken = 1'b1;
        #1;
        n_cmp++; if ({if_id_flush, flush, pc_we, stall} !== 4'b1110) begin n_fail++; $display("FAIL br_outs got %b want 1110", {if_id_flush, flush, pc_we, stall}); end
        step();
        branch_taken = 1'b0;
        n_cmp++; if (stage_valid !== 5'b11101) begin n_fail++; $display("FAIL br_sv got %b want 11101", stage_valid); end
        step();
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_dst = 4'd7; id_src1 = 4'd7; id_use1 = 1'b1;
        #1;
        n_cmp++; if ({if_id_flush, flush, stall} !== 3'b001) begin n_fail++; $display("FAIL br_masked got %b want 001", {if_id_flush, flush, stall}); end
        step();
        n_cmp++; if ({if_id_flush, stall} !== 2'b10) begin n_fail++; $display("FAIL br_reeval got %b want 10", {if_id_flush, stall}); end
        step();
        clear_inputs();
    endtask

    task automatic test_mem_busy();
        fill();
        mem_busy = 1'b1; branch_taken = 1'b1;
        #1;
        n_cmp++; if ({en, if_id_flush, id_ex_flush, stall} !== 7'b0000_001) begin n_fail++; $display("FAIL busy_outs got %b want 0000001", {en, if_id_flush, id_ex_flush, stall}); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if ({stage_valid, mem_timeout} !== 6'b11111_0) begin n_fail++; $display("FAIL busy_hold got %b want 111110", {stage_valid, mem_timeout}); end
        clear_inputs();
        step();
        mem_busy = 1'b1;
        for (int i = 0; i < 15; i++) step();
        n_cmp++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early got %b want 0", mem_timeout); end
        step();
        n_cmp++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_set got %b want 1", mem_timeout); end
        mem_busy = 1'b0;
        step();
        step();
        n_cmp++; if ({mem_timeout, stall, pc_we} !== 3'b101) begin n_fail++; $display("FAIL to_sticky got %b want 101", {mem_timeout, stall, pc_we}); end
    endtask

    task automatic test_halt();
        do_reset();
        n_cmp++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_to_clr got %b want 0", mem_timeout); end
        fill();
        id_halt = 1'b1;
        #1;
        n_cmp++; if ({pc_we, if_id_flush, if_id_we} !== 3'b011) begin n_fail++; $display("FAIL hlt_outs got %b want 011", {pc_we, if_id_flush, if_id_we}); end
        step();
        id_halt = 1'b0;
        n_cmp++; if ({halted, stage_valid, pc_we, if_id_flush} !== 8'b0_11100_01) begin n_fail++; $display("FAIL drain1 got %b want 01110001", {halted, stage_valid, pc_we, if_id_flush}); end
        step();
        n_cmp++; if ({halted, stage_valid} !== 6'b0_11000) begin n_fail++; $display("FAIL drain2 got %b want 011000", {halted, stage_valid}); end
        step();
        n_cmp++; if ({halted, stage_valid} !== 6'b0_10000) begin n_fail++; $display("FAIL drain3 got %b want 010000", {halted, stage_valid}); end
        step();
        n_cmp++; if ({halted, stage_valid, en} !== 10'b1_00000_0000) begin n_fail++; $display("FAIL halted got %b want 1000000000", {halted, stage_valid, en}); end
        branch_taken = 1'b1; mem_busy = 1'b1;
        step();
        step();
        n_cmp++; if ({halted, stage_valid, en, stall} !== 11'b1_00000_0000_0) begin n_fail++; $display("FAIL halted_hold got %b want 10000000000", {halted, stage_valid, en, stall}); end
        clear_inputs();
    endtask

    task automatic test_rst_mid_drain();
        do_reset();
        fill();
        id_halt = 1'b1;
        step();
        id_halt = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({halted, stage_valid, en, if_id_flush} !== 11'b0) begin n_fail++; $display("FAIL rst_drain got %b want 00000000000", {halted, stage_valid, en, if_id_flush}); end
        step();
        rst = 1'b0;
        step();
        n_cmp++; if ({stage_valid, pc_we, if_id_flush} !== 7'b00001_10) begin n_fail++; $display("FAIL rst_run got %b want 0000110", {stage_valid, pc_we, if_id_flush}); end
        fill();
        mem_busy = 1'b1;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({stall, stage_valid, en} !== 10'b0) begin n_fail++; $display("FAIL rst_freeze got %b want 0000000000", {stall, stage_valid, en}); end
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
    endtask

`ifdef PIPE_TRACE_EN
    task automatic test_trace();
        int exp_tag;
        int retired;
        do_reset();
        exp_tag = 0;
        retired = 0;
        for (int c = 0; c < 40 && retired < 10; c++) begin
            if (c == 8) begin
                ex_mem_read = 1'b1; ex_dst = 4'd2; id_src1 = 4'd2; id_use1 = 1'b1;
            end else begin
                clear_inputs();
            end
            #1;
            if (stage_valid[4]) begin
                n_cmp++; if (trace_ids[39:32] !== exp_tag[7:0]) begin n_fail++; $display("FAIL wb_tag got %0d want %0d", trace_ids[39:32], exp_tag); end
                exp_tag++;
                retired++;
            end
            step();
        end
        clear_inputs();
        n_cmp++; if (retire_cnt !== 16'd10 || retired != 10) begin n_fail++; $display("FAIL retire_cnt got %0d want 10 (seen %0d)", retire_cnt, retired); end
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_halt();
        test_rst_mid_drain();
`ifdef PIPE_TRACE_EN
        test_trace();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
